// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared definitions for the pipeline run-control sequencer: state encoding,
// halt opcode default and exception code type.
package Defs;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        FAULT
    } RunState_t;

    localparam int INSTR_W_DEF = 9;
    localparam logic [INSTR_W_DEF-1:0] HALT_OP_DEF = 9'b111000000;

    localparam int EXC_W_DEF = 2;
    typedef logic [EXC_W_DEF-1:0] ExcCode_t;

endpackage

// File: rtl/pipe_seq_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over enable.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Run-control sequencer: start/run/drain/done FSM, per-stage valid tracking,
// first EX exception capture and cycle / retired-instruction counters.
//
// state | meaning
// IDLE  | after reset, fetch disabled, waiting for start
// RUN   | fetching; valid bits shift with stall/flush rules
// DRAIN | halt seen in ID; no new fetches, pipeline empties out
// DONE  | pipeline empty after halt; done held until next start
// FAULT | EX exception captured; pipeline killed, done + exc_flag held
module pipe_seq_ctrl
    import Defs::*;
#(
    parameter int                 STAGES  = 5,
    parameter int                 INSTR_W = 9,
    parameter logic [INSTR_W-1:0] HALT_OP = INSTR_W'(HALT_OP_DEF),
    parameter int                 EXC_W   = 2,
    parameter int                 CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] id_instr,
    input  logic               stall,
    input  logic               flush,
    input  logic [EXC_W-1:0]   exc,
    output logic               fetch_en,
    output logic [STAGES-1:0]  stage_valid,
    output logic               busy,
    output logic               done,
    output logic               exc_flag,
    output logic [EXC_W-1:0]   exc_cause,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   retired_count
);

    localparam logic [STAGES-1:0] VALID_IF_ONLY = {{(STAGES-1){1'b0}}, 1'b1};

    RunState_t          r_state;
    RunState_t          w_state_next;
    logic [STAGES-1:0]  r_valid;
    logic [STAGES-1:0]  w_valid_next;
    logic               r_done;
    logic               r_exc_flag;
    logic [EXC_W-1:0]   r_exc_cause;
    logic               w_busy;
    logic               w_halt;
    logic               w_exc_hit;
    logic               w_enter_run;

    always_comb begin
        w_busy       = (r_state == RUN) || (r_state == DRAIN);
        w_exc_hit    = w_busy && (exc != '0) && r_valid[2];
        w_halt       = (r_state == RUN) && r_valid[1] && !stall && (id_instr == HALT_OP);
        w_enter_run  = start && !w_busy;
        w_state_next = r_state;
        unique case (r_state)
            IDLE, DONE, FAULT: begin
                if (start) w_state_next = RUN;
            end
            RUN: begin
                if (w_exc_hit)   w_state_next = FAULT;
                else if (w_halt) w_state_next = DRAIN;
            end
            DRAIN: begin
                if (w_exc_hit)           w_state_next = FAULT;
                else if (r_valid == '0)  w_state_next = DONE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Stages 0..2 carry the stall/flush/halt special cases; the rest just shift.
    always_comb begin
        w_valid_next = r_valid;
        if (w_enter_run) begin
            w_valid_next = VALID_IF_ONLY;
        end else if (w_exc_hit) begin
            w_valid_next = '0;
        end else if (w_busy) begin
            for (int i = 3; i < STAGES; i++) begin
                w_valid_next[i] = r_valid[i-1];
            end
            if (r_state == DRAIN) begin
                w_valid_next[0] = 1'b0;
                w_valid_next[1] = 1'b0;
                w_valid_next[2] = r_valid[1];
            end else if (w_halt) begin
                w_valid_next[0] = 1'b0;
                w_valid_next[1] = 1'b0;
                w_valid_next[2] = 1'b1;
            end else if (stall) begin
                w_valid_next[1] = r_valid[1] & !flush;
                w_valid_next[2] = 1'b0;
            end else begin
                w_valid_next[0] = 1'b1;
                w_valid_next[1] = r_valid[0] & !flush;
                w_valid_next[2] = r_valid[1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_done      <= 1'b0;
            r_exc_flag  <= 1'b0;
            r_exc_cause <= '0;
        end else begin
            r_state    <= w_state_next;
            r_valid    <= w_valid_next;
            r_done     <= (w_state_next == DONE) || (w_state_next == FAULT);
            r_exc_flag <= (w_state_next == FAULT);
            if (w_enter_run) begin
                r_exc_cause <= '0;
            end else if (w_exc_hit) begin
                r_exc_cause <= exc;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_enter_run),
        .en    (w_busy),
        .q     (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_retired_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_enter_run),
        .en    (w_busy && r_valid[STAGES-1]),
        .q     (retired_count)
    );

    assign fetch_en    = (r_state == RUN) && !stall;
    assign busy        = w_busy;
    assign done        = r_done;
    assign exc_flag    = r_exc_flag;
    assign exc_cause   = r_exc_cause;
    assign stage_valid = r_valid;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Self-checking bench for pipe_seq_ctrl: per-scenario tasks with a run-result
// scoreboard; a second CNT_W=4 instance shares the stimulus for saturation.
module tb_pipe_seq_ctrl;

    localparam logic [8:0] HALT = 9'b111000000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [8:0]  id_instr = '0;
    logic [1:0]  exc = '0;

    logic        fetch_en, busy, done, exc_flag;
    logic [4:0]  stage_valid;
    logic [1:0]  exc_cause;
    logic [15:0] cycle_count, retired_count;

    logic        fetch_en4, busy4, done4, exc_flag4;
    logic [4:0]  stage_valid4;
    logic [1:0]  exc_cause4;
    logic [3:0]  cycle_count4, retired_count4;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    typedef struct {
        string      name;
        int         done_edge;
        int         retired;
        int         cycles;
        logic       exc_flag;
        logic [1:0] cause;
    } exp_t;

    exp_t sb[$];

    pipe_seq_ctrl #(.STAGES(5), .INSTR_W(9), .HALT_OP(HALT), .EXC_W(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .id_instr(id_instr), .stall(stall),
        .flush(flush), .exc(exc), .fetch_en(fetch_en), .stage_valid(stage_valid),
        .busy(busy), .done(done), .exc_flag(exc_flag), .exc_cause(exc_cause),
        .cycle_count(cycle_count), .retired_count(retired_count)
    );

    pipe_seq_ctrl #(.STAGES(5), .INSTR_W(9), .HALT_OP(HALT), .EXC_W(2), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .id_instr(id_instr), .stall(stall),
        .flush(flush), .exc(exc), .fetch_en(fetch_en4), .stage_valid(stage_valid4),
        .busy(busy4), .done(done4), .exc_flag(exc_flag4), .exc_cause(exc_cause4),
        .cycle_count(cycle_count4), .retired_count(retired_count4)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        edge_n = 0;
    endtask

    task automatic wait_done();
        exp_t e;
        int   budget;
        budget = 30;
        while (done !== 1'b1 && budget > 0) begin
            step();
            budget--;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected run result queued");
            return;
        end
        e = sb.pop_front();
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: done=%b after budget, required 1", e.name, done);
        end
        checks++;
        if (edge_n != e.done_edge) begin
            errors++;
            $display("FAIL %s_done_edge: done rose after edge %0d, required %0d", e.name, edge_n, e.done_edge);
        end
        checks++;
        if (int'(retired_count) != e.retired) begin
            errors++;
            $display("FAIL %s_retired: got %0d, required %0d", e.name, retired_count, e.retired);
        end
        checks++;
        if (int'(cycle_count) != e.cycles) begin
            errors++;
            $display("FAIL %s_cycles: got %0d, required %0d", e.name, cycle_count, e.cycles);
        end
        checks++;
        if (stage_valid !== 5'b00000) begin
            errors++;
            $display("FAIL %s_stage_valid: got %b, required 00000", e.name, stage_valid);
        end
        checks++;
        if (exc_flag !== e.exc_flag || exc_cause !== e.cause) begin
            errors++;
            $display("FAIL %s_exc: got flag=%b cause=%b, required flag=%b cause=%b",
                     e.name, exc_flag, exc_cause, e.exc_flag, e.cause);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, exc_flag, fetch_en, stage_valid} !== 9'b0) begin
            errors++;
            $display("FAIL reset_held: busy=%b done=%b exc_flag=%b fetch_en=%b sv=%b, required all 0",
                     busy, done, exc_flag, fetch_en, stage_valid);
        end
        @(negedge clk) reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({busy, done, exc_flag, fetch_en, stage_valid, exc_cause} !== 11'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b exc_flag=%b fetch_en=%b sv=%b cause=%b, required all 0",
                     busy, done, exc_flag, fetch_en, stage_valid, exc_cause);
        end
        checks++;
        if (cycle_count !== 16'd0 || retired_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: cycle=%0d retired=%0d, required 0 0", cycle_count, retired_count);
        end
    endtask

    task automatic test_clean_halt();
        run_start();
        checks++;
        if (busy !== 1'b1 || fetch_en !== 1'b1 || stage_valid !== 5'b00001) begin
            errors++;
            $display("FAIL clean_start: busy=%b fetch_en=%b sv=%b, required 1 1 00001", busy, fetch_en, stage_valid);
        end
        for (int e = 1; e <= 9; e++) step();
        id_instr = HALT;
        sb.push_back('{"clean", 14, 9, 14, 1'b0, 2'b00});
        step();
        id_instr = '0;
        checks++;
        if (stage_valid !== 5'b11100 || fetch_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clean_halt_edge: sv=%b fetch_en=%b busy=%b, required 11100 0 1", stage_valid, fetch_en, busy);
        end
        wait_done();
        repeat (3) step();
        checks++;
        if (done !== 1'b1 || cycle_count !== 16'd14 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_done_hold: done=%b cycle=%0d busy=%b, required 1 14 0", done, cycle_count, busy);
        end
    endtask

    task automatic test_stall();
        run_start();
        for (int e = 1; e <= 5; e++) begin
            start = (e == 3);
            step();
        end
        start = 1'b0;
        stall = 1'b1;
        #1;
        checks++;
        if (fetch_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_fetch_en: got %b, required 0", fetch_en);
        end
        step();
        checks++;
        if (stage_valid !== 5'b11011 || fetch_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_edge6: sv=%b fetch_en=%b, required 11011 0", stage_valid, fetch_en);
        end
        step();
        checks++;
        if (stage_valid !== 5'b10011) begin
            errors++;
            $display("FAIL stall_edge7: sv=%b, required 10011", stage_valid);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (fetch_en !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_fetch_en: got %b, required 1", fetch_en);
        end
        for (int e = 8; e <= 9; e++) begin
            step();
            checks++;
            if (stage_valid[4] !== 1'b0) begin
                errors++;
                $display("FAIL stall_bubble_wb_edge%0d: wb=%b, required 0", e, stage_valid[4]);
            end
        end
        step();
        step();
        id_instr = HALT;
        sb.push_back('{"stall", 16, 9, 16, 1'b0, 2'b00});
        step();
        id_instr = '0;
        wait_done();
    endtask

    task automatic test_flush();
        run_start();
        for (int e = 1; e <= 4; e++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (stage_valid !== 5'b11101) begin
            errors++;
            $display("FAIL flush_kill_id: sv=%b, required 11101", stage_valid);
        end
        for (int e = 6; e <= 9; e++) step();
        flush    = 1'b1;
        id_instr = HALT;
        sb.push_back('{"flush", 14, 8, 14, 1'b0, 2'b00});
        step();
        flush    = 1'b0;
        id_instr = '0;
        checks++;
        if (stage_valid !== 5'b11100 || busy !== 1'b1 || fetch_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_halt_taken: sv=%b busy=%b fetch_en=%b, required 11100 1 0", stage_valid, busy, fetch_en);
        end
        wait_done();
    endtask

    task automatic test_exception();
        run_start();
        for (int e = 1; e <= 6; e++) step();
        exc = 2'b10;
        sb.push_back('{"exc", 7, 3, 7, 1'b1, 2'b10});
        step();
        exc = 2'b00;
        checks++;
        if (busy !== 1'b0 || fetch_en !== 1'b0) begin
            errors++;
            $display("FAIL exc_stopped: busy=%b fetch_en=%b, required 0 0", busy, fetch_en);
        end
        wait_done();
        run_start();
        checks++;
        if (exc_flag !== 1'b0 || done !== 1'b0 || exc_cause !== 2'b00 || stage_valid !== 5'b00001) begin
            errors++;
            $display("FAIL exc_restart: flag=%b done=%b cause=%b sv=%b, required 0 0 00 00001",
                     exc_flag, done, exc_cause, stage_valid);
        end
        checks++;
        if (cycle_count !== 16'd0 || retired_count !== 16'd0) begin
            errors++;
            $display("FAIL exc_restart_counters: cycle=%0d retired=%0d, required 0 0", cycle_count, retired_count);
        end
    endtask

    task automatic test_reset_drain();
        for (int e = 1; e <= 9; e++) step();
        id_instr = HALT;
        step();
        id_instr = '0;
        step();
        checks++;
        if (busy !== 1'b1 || stage_valid !== 5'b11000) begin
            errors++;
            $display("FAIL drain_reached: busy=%b sv=%b, required 1 11000", busy, stage_valid);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, exc_flag, fetch_en, stage_valid, exc_cause} !== 11'b0 ||
            cycle_count !== 16'd0 || retired_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_drain: busy=%b done=%b sv=%b cycle=%0d retired=%0d, required all 0",
                     busy, done, stage_valid, cycle_count, retired_count);
        end
        @(negedge clk) reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stage_valid !== 5'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b done=%b sv=%b, required 0 0 00000", busy, done, stage_valid);
        end
    endtask

    task automatic test_saturation();
        run_start();
        for (int e = 1; e <= 20; e++) step();
        checks++;
        if (cycle_count4 !== 4'hF || retired_count4 !== 4'hF) begin
            errors++;
            $display("FAIL sat_cnt4: cycle=%h retired=%h, required F F", cycle_count4, retired_count4);
        end
        checks++;
        if (cycle_count !== 16'd20 || retired_count !== 16'd16) begin
            errors++;
            $display("FAIL sat_cnt16: cycle=%0d retired=%0d, required 20 16", cycle_count, retired_count);
        end
    endtask

    initial begin
        test_reset();
        test_clean_halt();
        test_stall();
        test_flush();
        test_exception();
        test_reset_drain();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
